// File: rtl/issue_select_pkg.sv
// -----------------------------------------------------------------------------
// issue_select_pkg
// Layout of the shared slot read bus, used by the issue slots and by
// issue_select. The bus is packed MSB to LSB as
//   {UOPCode[6:0], BrMask, Tag, Bank[1:0], RD, RS2, RS1}
// The register, tag and branch-mask widths are parameters of the users, so
// the field offsets are functions of those widths.
// -----------------------------------------------------------------------------
package issue_select_pkg;

    localparam int UOP_W  = 7;
    localparam int BANK_W = 2;

    function automatic int rs1_lsb();
        return 0;
    endfunction

    function automatic int rs2_lsb(input int wr);
        return wr;
    endfunction

    function automatic int rd_lsb(input int wr);
        return 2 * wr;
    endfunction

    function automatic int bank_lsb(input int wr);
        return 3 * wr;
    endfunction

    function automatic int tag_lsb(input int wr);
        return 3 * wr + BANK_W;
    endfunction

    function automatic int brm_lsb(input int wr, input int wt);
        return tag_lsb(wr) + wt;
    endfunction

    function automatic int uop_lsb(input int wr, input int wt, input int wb);
        return brm_lsb(wr, wt) + wb;
    endfunction

    function automatic int bus_width(input int wr, input int wt, input int wb);
        return uop_lsb(wr, wt, wb) + UOP_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at the internal pointer and grants
// the first requesting index at or above it, wrapping to 0. After a grant to
// index k the pointer moves to (k+1) mod N; without a grant it holds.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (pointer to 0)
//   req   : per-index request
//   en    : grant enable; grant is forced to 0 when low
//   grant : one-hot or zero grant, combinational
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] pos;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = PTR_W'((int'(ptr_q) + i) % N);
            if (en && !found && req[pos]) begin
                grant[pos] = 1'b1;
                gnt_idx    = pos;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/issue_select.sv
// -----------------------------------------------------------------------------
// issue_select
// Picks one ready issue slot per cycle (round robin), captures its read bus
// into the issue register feeding the functional unit, and broadcasts the
// issued destination register on the wakeup bus LATENCY cycles later.
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset
//   i_request  : per-slot request (valid & p1 & p2)
//   o_grant    : one-hot or zero grant, combinational
//   i_rslot    : shared slot read bus, meaningful only while a grant is given
//   i_BrKill   : {enKill, BranchMask}
//   i_fu_ready : functional unit accepts o_uop this cycle
//   o_valid    : issue register holds a live uop
//   o_uop      : issue register contents
//   o_WDest    : wakeup destination register, 0 when idle
// -----------------------------------------------------------------------------
module issue_select
    import issue_select_pkg::*;
#(
    parameter int N_SLOT    = 8,
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_TAG = 5,
    parameter int WIDTH_BRM = 3,
    parameter int LATENCY   = 1,
    parameter int WIDTH_O   = bus_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_SLOT-1:0]    i_request,
    output logic [N_SLOT-1:0]    o_grant,
    input  logic [WIDTH_O-1:0]   i_rslot,
    input  logic [WIDTH_BRM:0]   i_BrKill,
    input  logic                 i_fu_ready,
    output logic                 o_valid,
    output logic [WIDTH_O-1:0]   o_uop,
    output logic [WIDTH_REG-1:0] o_WDest
);

    localparam int RD_LSB  = rd_lsb(WIDTH_REG);
    localparam int BRM_LSB = brm_lsb(WIDTH_REG, WIDTH_TAG);

    // Same equality rule the issue slots apply.
    function automatic logic br_killed(input logic [WIDTH_BRM-1:0] brm,
                                       input logic [WIDTH_BRM:0]   bk);
        return bk[WIDTH_BRM] && (brm == bk[WIDTH_BRM-1:0]);
    endfunction

    logic                 valid_q, valid_d;
    logic [WIDTH_O-1:0]   uop_q, uop_d;
    logic                 can_issue;
    logic                 grant_any;
    logic                 in_kill;
    logic                 held_kill;
    logic [WIDTH_BRM-1:0] in_brm;
    logic [WIDTH_REG-1:0] in_rd;

    logic                 wk_v_q   [LATENCY];
    logic [WIDTH_BRM-1:0] wk_brm_q [LATENCY];
    logic [WIDTH_REG-1:0] wk_rd_q  [LATENCY];
    logic [WIDTH_REG-1:0] wdest_q;

    assign can_issue = ~valid_q | i_fu_ready;
    assign in_brm    = i_rslot[BRM_LSB +: WIDTH_BRM];
    assign in_rd     = i_rslot[RD_LSB +: WIDTH_REG];
    assign in_kill   = br_killed(in_brm, i_BrKill);
    assign held_kill = br_killed(uop_q[BRM_LSB +: WIDTH_BRM], i_BrKill);
    assign grant_any = |o_grant;

    // Reset also gates the enable so no grant is shown while reset is held.
    rr_arbiter #(
        .N (N_SLOT)
    ) u_arb (
        .clk   (i_clk),
        .rst   (i_rst),
        .req   (i_request),
        .en    (can_issue & ~i_rst),
        .grant (o_grant)
    );

    // Issue register next state
    always_comb begin
        valid_d = valid_q;
        uop_d   = uop_q;
        if (grant_any) begin
            uop_d   = i_rslot;
            valid_d = ~in_kill;
        end else if (valid_q & i_fu_ready) begin
            valid_d = 1'b0;
        end else if (valid_q & held_kill) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            uop_q   <= '0;
        end else begin
            valid_q <= valid_d;
            uop_q   <= uop_d;
        end
    end

    // Wakeup pipeline: valid bits and the broadcast register. The output
    // register is the final hop, so o_WDest appears LATENCY cycles after the
    // issue register load; a kill is applied on every hop including that one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                wk_v_q[i] <= 1'b0;
            end
            wdest_q <= '0;
        end else begin
            wk_v_q[0] <= grant_any & ~in_kill;
            for (int i = 1; i < LATENCY; i++) begin
                wk_v_q[i] <= wk_v_q[i-1] & ~br_killed(wk_brm_q[i-1], i_BrKill);
            end
            wdest_q <= (wk_v_q[LATENCY-1] & ~br_killed(wk_brm_q[LATENCY-1], i_BrKill))
                       ? wk_rd_q[LATENCY-1] : '0;
        end
    end

    // Wakeup pipeline: payload, qualified by the valid bits above
    always_ff @(posedge i_clk) begin
        wk_brm_q[0] <= in_brm;
        wk_rd_q[0]  <= in_rd;
        for (int i = 1; i < LATENCY; i++) begin
            wk_brm_q[i] <= wk_brm_q[i-1];
            wk_rd_q[i]  <= wk_rd_q[i-1];
        end
    end

    assign o_valid = valid_q;
    assign o_uop   = uop_q;
    assign o_WDest = wdest_q;

endmodule

// File: tb/tb_issue_select.sv
module tb_issue_select;

    localparam int NS = 8;
    localparam int WO = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] req;
    logic [NS-1:0] grant;
    logic [WO-1:0] rslot;
    logic [3:0]    bk;
    logic          fu;
    logic          valid;
    logic [WO-1:0] uop;
    logic [4:0]    wdest;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [4:0] rd;
        int         cyc;
    } wake_t;

    logic [WO-1:0] iq[$];
    wake_t         wq[$];
    logic [WO-1:0] slot_uop[NS];

    issue_select #(
        .N_SLOT    (NS),
        .WIDTH_REG (5),
        .WIDTH_TAG (5),
        .WIDTH_BRM (3),
        .LATENCY   (LAT),
        .WIDTH_O   (WO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_request  (req),
        .o_grant    (grant),
        .i_rslot    (rslot),
        .i_BrKill   (bk),
        .i_fu_ready (fu),
        .o_valid    (valid),
        .o_uop      (uop),
        .o_WDest    (wdest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Only the granted slot drives the read bus.
    always_comb begin
        rslot = '0;
        for (int i = 0; i < NS; i++) begin
            if (grant[i]) rslot = slot_uop[i];
        end
    end

    function automatic logic [WO-1:0] mk(input logic [6:0] op, input logic [2:0] brm,
                                         input logic [4:0] tag, input logic [1:0] bank,
                                         input logic [4:0] rd, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
        return {op, brm, tag, bank, rd, rs2, rs1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expect slot s to be issued (accepted later) and woken 3 negedges from now.
    task automatic expect_slot(input int s);
        wake_t w;
        logic [WO-1:0] u;
        u = slot_uop[s];
        iq.push_back(u);
        w.rd  = u[14:10];
        w.cyc = cyc + LAT + 1;
        wq.push_back(w);
    endtask

    task automatic step(input logic [NS-1:0] r, input logic f, input logic [3:0] k);
        @(posedge clk);
        #1;
        req = r;
        fu  = f;
        bk  = k;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 4'b0000);
    endtask

    // Monitor: consumes expected entries whenever the DUT presents output.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && fu) begin
                if (iq.size() == 0) begin
                    chk("unexpected_issue", uop, 32'hdead_beef);
                end else begin
                    logic [WO-1:0] e;
                    e = iq.pop_front();
                    chk("issue_uop", uop, e);
                end
            end
            if (wdest != 5'd0) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wake", {27'd0, wdest}, 32'd0);
                end else begin
                    wake_t w;
                    w = wq.pop_front();
                    chk("wake_rd", {27'd0, wdest}, {27'd0, w.rd});
                    chk("wake_cycle", cyc, w.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        slot_uop[0] = mk(7'h11, 3'b001, 5'd0, 2'd0, 5'd1, 5'd10, 5'd11);
        slot_uop[1] = mk(7'h22, 3'b010, 5'd1, 2'd1, 5'd9, 5'd12, 5'd13);
        slot_uop[2] = mk(7'h33, 3'b011, 5'd2, 2'd2, 5'd2, 5'd14, 5'd15);
        slot_uop[3] = mk(7'h44, 3'b001, 5'd3, 2'd3, 5'd3, 5'd16, 5'd17);
        slot_uop[4] = mk(7'h55, 3'b100, 5'd4, 2'd0, 5'd4, 5'd18, 5'd19);
        slot_uop[5] = mk(7'h66, 3'b101, 5'd5, 2'd1, 5'd5, 5'd20, 5'd21);
        slot_uop[6] = mk(7'h77, 3'b110, 5'd6, 2'd2, 5'd6, 5'd22, 5'd23);
        slot_uop[7] = mk(7'h08, 3'b111, 5'd7, 2'd3, 5'd7, 5'd24, 5'd25);

        rst = 1'b1; req = 8'hFF; fu = 1'b1; bk = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {24'd0, grant}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_wdest", {27'd0, wdest}, 32'd0);
        chk("rst_uop", uop, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = '0;

        // Round robin, held requests from slots 0, 2, 7
        step(8'h85, 1'b1, 4'b0000); chk("rr0", {24'd0, grant}, 32'h01); expect_slot(0);
        step(8'h85, 1'b1, 4'b0000); chk("rr1", {24'd0, grant}, 32'h04); expect_slot(2);
        step(8'h85, 1'b1, 4'b0000); chk("rr2", {24'd0, grant}, 32'h80); expect_slot(7);
        step(8'h85, 1'b1, 4'b0000); chk("rr3", {24'd0, grant}, 32'h01); expect_slot(0);
        idle(4);

        // Stall with a pending request
        step(8'h08, 1'b0, 4'b0000); chk("stall_first", {24'd0, grant}, 32'h08); expect_slot(3);
        step(8'h40, 1'b0, 4'b0000); chk("stall_gnt0", {24'd0, grant}, 32'h00);
        chk("stall_uop0", uop, slot_uop[3]);
        step(8'h40, 1'b0, 4'b0000); chk("stall_gnt1", {24'd0, grant}, 32'h00);
        chk("stall_uop1", uop, slot_uop[3]);
        step(8'h40, 1'b1, 4'b0000); chk("stall_release", {24'd0, grant}, 32'h40); expect_slot(6);
        idle(4);

        // Kill while held in the issue register, then a non-matching kill
        step(8'h02, 1'b0, 4'b0000); chk("kill_gnt", {24'd0, grant}, 32'h02);
        step(8'h00, 1'b0, 4'b1010); chk("kill_held_valid", {31'd0, valid}, 32'd1);
        step(8'h00, 1'b0, 4'b0000); chk("kill_cleared", {31'd0, valid}, 32'd0);
        step(8'h02, 1'b0, 4'b0000); chk("nokill_gnt", {24'd0, grant}, 32'h02); expect_slot(1);
        step(8'h00, 1'b0, 4'b1011); chk("nokill_valid", {31'd0, valid}, 32'd1);
        step(8'h00, 1'b1, 4'b0000); chk("nokill_still", {31'd0, valid}, 32'd1);
        idle(4);

        // Grant and kill in the same cycle
        step(8'h10, 1'b1, 4'b1100); chk("sim_gnt", {24'd0, grant}, 32'h10);
        step(8'h11, 1'b1, 4'b0000); chk("sim_valid", {31'd0, valid}, 32'd0);
        chk("sim_ptr", {24'd0, grant}, 32'h01); expect_slot(0);
        idle(4);

        // Asynchronous reset mid-cycle with a held uop and a pending wakeup
        step(8'h01, 1'b1, 4'b0000); chk("mr_a", {24'd0, grant}, 32'h01); expect_slot(0);
        step(8'h04, 1'b1, 4'b0000); chk("mr_b", {24'd0, grant}, 32'h04);
        step(8'h00, 1'b0, 4'b0000);
        step(8'hFF, 1'b0, 4'b0000); chk("mr_wdest_before", {27'd0, wdest}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", {31'd0, valid}, 32'd0);
        chk("mr_wdest", {27'd0, wdest}, 32'd0);
        chk("mr_grant", {24'd0, grant}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 8'h84; fu = 1'b1; bk = 4'b0000;
        @(negedge clk);
        chk("post_rst_lowest", {24'd0, grant}, 32'h04); expect_slot(2);
        idle(6);

        chk("issue_q_empty", iq.size(), 32'd0);
        chk("wake_q_empty", wq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
